// File: rtl/wbram_rd_stream_ctrl.sv
// Weight-BRAM read controller for one PE column.
// Takes per-layer descriptors, forwards each one to the neighbouring PE,
// waits for the writer to fill a buffer, then streams that buffer's words to
// the systolic array. A credit-managed skid FIFO hides the BRAM read latency,
// and the buffer is handed back to the writer once every word is delivered.
module wbram_rd_stream_ctrl #(
    parameter int  WEIGHT_BIT = 8,
    parameter int  LANES      = 16,
    parameter int  NUM_BUFS   = 2,
    parameter int  BUF_WORDS  = 512,
    parameter int  RD_LAT     = 1,
    parameter int  FIFO_DEPTH = RD_LAT + 2,
    parameter int  LEN_W      = $clog2(BUF_WORDS) + 1,
    localparam int SW         = LANES * WEIGHT_BIT,
    localparam int ADDR_W     = $clog2(NUM_BUFS * BUF_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LEN_W-1:0]  desc_words,
    input  logic              desc_last,
    input  logic              desc_valid,
    output logic              desc_ready,
    output logic [LEN_W-1:0]  fwd_words,
    output logic              fwd_last,
    output logic              fwd_valid,
    input  logic              fwd_ready,
    input  logic              buf_filled,
    output logic              buf_free,
    output logic [ADDR_W-1:0] addrB,
    output logic              enaB,
    output logic              weB,
    input  logic [SW-1:0]     doB,
    output logic [SW-1:0]     w_sys_data,
    output logic              w_sys_valid,
    input  logic              w_sys_ready,
    output logic              net_done
);

    localparam int OFF_W  = $clog2(BUF_WORDS);
    localparam int BUF_W  = $clog2(NUM_BUFS);
    localparam int FILL_W = $clog2(NUM_BUFS) + 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int INF_W  = $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FWD,
        ST_WAIT_BUF,
        ST_STREAM,
        ST_DRAIN
    } state_t;

    state_t             r_state;
    logic [LEN_W-1:0]   r_words;
    logic               r_last;
    logic [LEN_W-1:0]   r_rd_cnt;
    logic [BUF_W-1:0]   r_rd_buf;
    logic               r_err;

    logic [FILL_W-1:0]  r_filled;
    logic               r_ovf;

    logic [RD_LAT-1:0]  r_vld;
    logic [SW-1:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [FCNT_W-1:0]  r_fifo_count;

    logic [INF_W-1:0]   w_inflight;
    logic               w_push;
    logic               w_pop;
    logic               w_credit_ok;
    logic               w_ena;
    logic               w_done;
    logic               w_have_buf;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Count reads issued to the BRAM whose data has not yet been pushed.
    always_comb begin
        // NOTE: default assigned first so no path leaves the sum unassigned (no latch).
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + INF_W'(r_vld[i]);
        end
    end

    assign w_push      = r_vld[RD_LAT-1];
    assign w_sys_valid = (r_fifo_count != '0);
    assign w_pop       = w_sys_valid && w_sys_ready;
    assign w_sys_data  = w_sys_valid ? r_mem[r_rd_ptr] : '0;

    // A read may only go out if its word is guaranteed a FIFO slot on return.
    assign w_credit_ok = (int'(r_fifo_count) + int'(w_inflight) + 1) <= (FIFO_DEPTH + int'(w_pop));
    assign w_ena       = (r_state == ST_STREAM) && (r_rd_cnt < r_words) && w_credit_ok;
    assign enaB        = w_ena;
    assign weB         = 1'b0;
    assign addrB       = w_ena ? {r_rd_buf, r_rd_cnt[OFF_W-1:0]} : '0;

    assign w_done      = (r_state == ST_DRAIN) && (w_inflight == '0) && (r_fifo_count == '0);
    assign buf_free    = w_done;
    assign net_done    = w_done && r_last;
    assign w_have_buf  = (r_filled != '0) || buf_filled;

    assign desc_ready  = (r_state == ST_IDLE) && !rst;
    assign fwd_valid   = (r_state == ST_FWD);
    assign fwd_words   = r_words;
    assign fwd_last    = r_last;

    // Layer sequencing: accept descriptor, forward it, wait for data, stream, drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state always uses non-blocking assignments.
            r_state  <= ST_IDLE;
            r_words  <= '0;
            r_last   <= 1'b0;
            r_rd_cnt <= '0;
            r_rd_buf <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (desc_valid) begin
                        // A zero-length layer is illegal; stream one word so the buffer still cycles.
                        if (desc_words == '0) begin
                            r_words <= LEN_W'(1);
                            r_err   <= 1'b1;
                        end else begin
                            r_words <= desc_words;
                        end
                        r_last  <= desc_last;
                        r_state <= ST_FWD;
                    end
                end
                ST_FWD: begin
                    if (fwd_ready) begin
                        r_state <= ST_WAIT_BUF;
                    end
                end
                ST_WAIT_BUF: begin
                    if (w_have_buf) begin
                        r_rd_cnt <= '0;
                        r_state  <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_ena) begin
                        r_rd_cnt <= r_rd_cnt + LEN_W'(1);
                        if (r_rd_cnt == r_words - LEN_W'(1)) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_done) begin
                        r_rd_buf <= r_rd_buf + BUF_W'(1);
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Filled-buffer count shared with the writer; a fill beyond capacity is dropped and flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_filled <= '0;
            r_ovf    <= 1'b0;
        end else if (buf_filled && !w_done) begin
            if (r_filled == FILL_W'(NUM_BUFS)) begin
                r_ovf <= 1'b1;
            end else begin
                r_filled <= r_filled + FILL_W'(1);
            end
        end else if (!buf_filled && w_done) begin
            r_filled <= r_filled - FILL_W'(1);
        end
    end

    // Read-latency tracker and skid FIFO occupancy/pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld        <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fifo_count <= '0;
        end else begin
            r_vld[0] <= w_ena;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
            if (w_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_count <= r_fifo_count + FCNT_W'(1);
                2'b01:   r_fifo_count <= r_fifo_count - FCNT_W'(1);
                default: r_fifo_count <= r_fifo_count;
            endcase
        end
    end

    // Skid FIFO storage; every returning BRAM word is captured.
    // NOTE: storage is not reset; the occupancy count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= doB;
        end
    end

    a_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push && !w_pop && (r_fifo_count == FCNT_W'(FIFO_DEPTH))));
    a_fill_no_overflow: assert property (@(posedge clk) disable iff (rst) !r_ovf);
    a_desc_words_legal: assert property (@(posedge clk) disable iff (rst) !r_err);

endmodule

// File: tb/tb_wbram_rd_stream_ctrl.sv
// Self-checking bench for wbram_rd_stream_ctrl: table-driven layers,
// hand-written corner sequences and randomized layers, all checked against
// a queue-based model of which words each layer must read and deliver.
module tb_wbram_rd_stream_ctrl;

    localparam int WEIGHT_BIT = 8;
    localparam int LANES      = 2;
    localparam int NUM_BUFS   = 2;
    localparam int BUF_WORDS  = 16;
    localparam int RD_LAT     = 2;
    localparam int FIFO_DEPTH = RD_LAT + 2;
    localparam int LEN_W      = $clog2(BUF_WORDS) + 1;
    localparam int SW         = LANES * WEIGHT_BIT;
    localparam int ADDR_W     = $clog2(NUM_BUFS * BUF_WORDS);

    logic              clk;
    logic              rst;
    logic [LEN_W-1:0]  desc_words;
    logic              desc_last;
    logic              desc_valid;
    logic              desc_ready;
    logic [LEN_W-1:0]  fwd_words;
    logic              fwd_last;
    logic              fwd_valid;
    logic              fwd_ready;
    logic              buf_filled;
    logic              buf_free;
    logic [ADDR_W-1:0] addrB;
    logic              enaB;
    logic              weB;
    logic [SW-1:0]     doB;
    logic [SW-1:0]     w_sys_data;
    logic              w_sys_valid;
    logic              w_sys_ready;
    logic              net_done;

    wbram_rd_stream_ctrl #(
        .WEIGHT_BIT (WEIGHT_BIT),
        .LANES      (LANES),
        .NUM_BUFS   (NUM_BUFS),
        .BUF_WORDS  (BUF_WORDS),
        .RD_LAT     (RD_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .desc_words  (desc_words),
        .desc_last   (desc_last),
        .desc_valid  (desc_valid),
        .desc_ready  (desc_ready),
        .fwd_words   (fwd_words),
        .fwd_last    (fwd_last),
        .fwd_valid   (fwd_valid),
        .fwd_ready   (fwd_ready),
        .buf_filled  (buf_filled),
        .buf_free    (buf_free),
        .addrB       (addrB),
        .enaB        (enaB),
        .weB         (weB),
        .doB         (doB),
        .w_sys_data  (w_sys_data),
        .w_sys_valid (w_sys_valid),
        .w_sys_ready (w_sys_ready),
        .net_done    (net_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Distinct content per BRAM address (odd multiplier is a bijection mod 2^16).
    function automatic logic [SW-1:0] bram_word(input int a);
        return SW'((a * 40503 + 12345) & 32'hffff);
    endfunction

    // BRAM model: data for an enabled read appears on doB RD_LAT cycles later.
    logic [SW-1:0] bram_pipe [RD_LAT];
    always @(posedge clk) begin
        bram_pipe[0] <= enaB ? bram_word(int'(addrB)) : SW'(16'hdead);
        for (int i = 1; i < RD_LAT; i++) bram_pipe[i] <= bram_pipe[i-1];
    end
    assign doB = bram_pipe[RD_LAT-1];

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int   model_buf = 0;
    int   exp_addr[$];
    logic [SW-1:0] exp_data[$];
    int   exp_fwd_words = 0;
    bit   exp_fwd_last  = 1'b0;
    bit   cur_last      = 1'b0;

    int n_issued = 0, n_accepted = 0, n_free = 0, n_done = 0;
    int lay_issued = 0, lay_acc = 0, first_addr = 0;
    int first_ena_cyc = 0, last_ena_cyc = 0, first_valid_cyc = 0;
    int first_acc_cyc = 0, last_acc_cyc = 0, fill_cyc = 0;
    bit lay_valid_seen = 1'b0;
    logic mon_pop;

    // A layer reads words 0..n-1 of the next buffer in round-robin order.
    task automatic start_model(input int words, input bit last);
        int base;
        base = model_buf * BUF_WORDS;
        for (int k = 0; k < words; k++) begin
            exp_addr.push_back(base + k);
            exp_data.push_back(bram_word(base + k));
        end
        model_buf      = (model_buf + 1) % NUM_BUFS;
        exp_fwd_words  = words;
        exp_fwd_last   = last;
        cur_last       = last;
        lay_issued     = 0;
        lay_acc        = 0;
        lay_valid_seen = 1'b0;
    endtask

    // Per-cycle monitor, sampled mid-cycle while inputs are stable.
    always @(negedge clk) begin
        if (!rst) begin
            mon_pop = w_sys_valid && w_sys_ready;
            check("occupancy_bound", (n_issued - n_accepted) <= FIFO_DEPTH, 1);
            if (enaB) begin
                check("credit_respected", (n_issued - n_accepted - int'(mon_pop) + 1) <= FIFO_DEPTH, 1);
                if (exp_addr.size() == 0) check("unexpected_read", enaB, 0);
                else                      check("addrB", addrB, exp_addr.pop_front());
                if (lay_issued == 0) begin
                    first_ena_cyc = cyc;
                    first_addr    = int'(addrB);
                end
                last_ena_cyc = cyc;
                lay_issued++;
                n_issued++;
            end
            if (w_sys_valid && !lay_valid_seen) begin
                first_valid_cyc = cyc;
                lay_valid_seen  = 1'b1;
            end
            if (mon_pop) begin
                if (exp_data.size() == 0) check("unexpected_word", mon_pop, 0);
                else                      check("w_sys_data", w_sys_data, exp_data.pop_front());
                if (lay_acc == 0) first_acc_cyc = cyc;
                last_acc_cyc = cyc;
                lay_acc++;
                n_accepted++;
            end
            if (fwd_valid) begin
                check("fwd_words", fwd_words, exp_fwd_words);
                check("fwd_last", fwd_last, exp_fwd_last);
            end
            if (buf_free) begin
                check("free_after_all_words", exp_data.size(), 0);
                n_free++;
            end
            if (buf_free || net_done) check("net_done", net_done, buf_free && cur_last);
            if (net_done) n_done++;
        end
    end

    // ---------------- stimulus drivers ----------------
    int ready_mode = 0;  // 0 high, 1 toggle, 2 random, 3 low
    int fwd_mode   = 0;  // 0 high, 1 random, 2 low

    initial begin
        w_sys_ready = 1'b1;
        fwd_ready   = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       w_sys_ready = 1'b1;
                1:       w_sys_ready = !w_sys_ready;
                2:       w_sys_ready = 1'($urandom_range(0, 1));
                default: w_sys_ready = 1'b0;
            endcase
            case (fwd_mode)
                0:       fwd_ready = 1'b1;
                1:       fwd_ready = 1'($urandom_range(0, 1));
                default: fwd_ready = 1'b0;
            endcase
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_desc(input int words, input bit last);
        bit ok;
        start_model(words, last);
        desc_words = LEN_W'(words);
        desc_last  = last;
        desc_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (desc_ready) ok = 1'b1;
            next_cycle();
        end
        desc_valid = 1'b0;
        check("desc_accepted_in_time", ok, 1);
    endtask

    task automatic pulse_filled();
        buf_filled = 1'b1;
        fill_cyc   = cyc;
        next_cycle();
        buf_filled = 1'b0;
    endtask

    task automatic wait_free(input int start, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            next_cycle();
            if (n_free > start) ok = 1'b1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_desc_ready"}, desc_ready, 0);
        check({tag, "_fwd_valid"}, fwd_valid, 0);
        check({tag, "_buf_free"}, buf_free, 0);
        check({tag, "_enaB"}, enaB, 0);
        check({tag, "_addrB"}, addrB, 0);
        check({tag, "_weB"}, weB, 0);
        check({tag, "_w_sys_valid"}, w_sys_valid, 0);
        check({tag, "_w_sys_data"}, w_sys_data, 0);
        check({tag, "_net_done"}, net_done, 0);
    endtask

    task automatic run_layer(input int words, input bit last, input int rmode, input int fmode,
                             input int fill_delay, input int exp_base, input int exp_done,
                             input string tag);
        int f0, d0;
        bit ok;
        f0 = n_free;
        d0 = n_done;
        ready_mode = rmode;
        fwd_mode   = fmode;
        send_desc(words, last);
        repeat (fill_delay) next_cycle();
        pulse_filled();
        wait_free(f0, 600, ok);
        check({tag, "_buf_free_seen"}, ok, 1);
        next_cycle();
        check({tag, "_base_addr"}, first_addr, exp_base);
        check({tag, "_words_read"}, lay_issued, words);
        check({tag, "_words_delivered"}, lay_acc, words);
        check({tag, "_buf_free_pulses"}, n_free - f0, 1);
        check({tag, "_net_done_pulses"}, n_done - d0, exp_done);
        if (rmode == 0) begin
            check({tag, "_first_word_latency"}, first_valid_cyc - first_ena_cyc, RD_LAT + 1);
            check({tag, "_read_burst_len"}, last_ena_cyc - first_ena_cyc, words - 1);
            check({tag, "_deliver_burst_len"}, last_acc_cyc - first_acc_cyc, words - 1);
        end
    endtask

    typedef struct {
        int words;
        bit last;
        int rmode;
        int exp_base;
        int exp_done;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   f0, d0, base, words;
        bit   ok, last;

        vecs[0] = '{4,  1'b1, 0, 0,         1};
        vecs[1] = '{10, 1'b0, 1, BUF_WORDS, 0};
        vecs[2] = '{1,  1'b0, 0, 0,         0};
        vecs[3] = '{16, 1'b1, 2, BUF_WORDS, 1};
        vecs[4] = '{7,  1'b0, 1, 0,         0};
        vecs[5] = '{3,  1'b0, 0, BUF_WORDS, 0};

        rst        = 1'b1;
        desc_words = '0;
        desc_last  = 1'b0;
        desc_valid = 1'b0;
        buf_filled = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // Table-driven layers, including buffer wrap across six layers.
        for (int r = 0; r < 6; r++) begin
            run_layer(vecs[r].words, vecs[r].last, vecs[r].rmode, 0, 0,
                      vecs[r].exp_base, vecs[r].exp_done, $sformatf("vec%0d", r));
        end

        // Starvation: no filled buffer must leave the reader idle on the BRAM.
        f0 = n_free;
        ready_mode = 0;
        fwd_mode   = 0;
        send_desc(5, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("starve_enaB_low", enaB, 0);
            next_cycle();
        end
        check("starve_no_reads", lay_issued, 0);
        pulse_filled();
        wait_free(f0, 300, ok);
        check("starve_buf_free_seen", ok, 1);
        check("starve_stream_start_latency", first_ena_cyc - fill_cyc, 1);
        check("starve_base_addr", first_addr, 0);
        check("starve_words_delivered", lay_acc, 5);
        next_cycle();

        // Neighbour stall: descriptor held on the forward port, no reads meanwhile.
        f0 = n_free;
        d0 = n_done;
        ready_mode = 0;
        fwd_mode   = 2;
        pulse_filled();
        send_desc(6, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_fwd_valid_held", fwd_valid, 1);
            check("stall_no_reads", enaB, 0);
            next_cycle();
        end
        fwd_mode = 0;
        wait_free(f0, 300, ok);
        check("stall_buf_free_seen", ok, 1);
        next_cycle();
        check("stall_base_addr", first_addr, BUF_WORDS);
        check("stall_words_delivered", lay_acc, 6);
        check("stall_net_done_pulses", n_done - d0, 1);

        // Randomized layers with random backpressure, forward stalls and fill timing.
        for (int r = 0; r < 12; r++) begin
            words = $urandom_range(1, BUF_WORDS);
            last  = 1'($urandom_range(0, 1));
            base  = model_buf * BUF_WORDS;
            run_layer(words, last, 2, 1, $urandom_range(0, 6), base, last ? 1 : 0,
                      $sformatf("rnd%0d", r));
        end

        // Reset in the middle of a stream after three delivered words.
        f0 = n_free;
        ready_mode = 0;
        fwd_mode   = 0;
        send_desc(8, 1'b0);
        pulse_filled();
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (lay_acc >= 3) ok = 1'b1;
            else next_cycle();
        end
        check("midrst_three_words_seen", ok, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midrst");
        check("midrst_no_buf_free", n_free - f0, 0);
        exp_addr.delete();
        exp_data.delete();
        model_buf  = 0;
        n_issued   = 0;
        n_accepted = 0;
        next_cycle();
        rst = 1'b0;
        repeat (5) next_cycle();
        check("postrst_no_buf_free", n_free - f0, 0);
        check("postrst_nothing_delivered", n_accepted, 0);

        run_layer(4, 1'b1, 0, 0, 0, 0, 1, "postrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
